mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 1R1W synchronous memory (registered read, 1-cycle
// latency) between NUM_REQ requesters. One transaction per cycle, round-robin
// grants with bursts bounded by BURST_MAX, read data routed back one-hot.
// Optional macro MEM_ARB_FIXED_PRIO_EN: strict fixed priority (lowest index
// wins); the burst counter and round-robin pointer are then not built.
module mem_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 1024,
   parameter int BURST_MAX = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NUM_REQ-1:0]                   req_valid_i,
   output logic [NUM_REQ-1:0]                   req_ready_o,
   input  logic [NUM_REQ-1:0]                   req_we_i,
   input  logic [NUM_REQ*$clog2(DEPTH)-1:0]     req_addr_i,
   input  logic [NUM_REQ*WIDTH-1:0]             req_wdata_i,
   output logic [NUM_REQ-1:0]                   resp_valid_o,
   output logic [WIDTH-1:0]                     resp_data_o,
   output logic                                 mem_read_en_o,
   output logic [$clog2(DEPTH)-1:0]             mem_read_pos_o,
   input  logic [WIDTH-1:0]                     mem_read_data_i,
   output logic                                 mem_write_en_o,
   output logic [$clog2(DEPTH)-1:0]             mem_write_pos_o,
   output logic [WIDTH-1:0]                     mem_write_data_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(NUM_REQ);

   logic              grant_valid;
   logic [IW-1:0]     grant_idx;
   logic [NUM_REQ-1:0] resp_pend_q;

`ifndef MEM_ARB_FIXED_PRIO_EN
   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OWNED = 1'b1;

   logic [0:0]    state_q;
   logic [IW-1:0] owner_q;
   logic [IW-1:0] last_q;
   logic [CW-1:0] burst_q;
   logic          keep;
   logic [IW-1:0] cand;

   // Keep the current owner while its burst budget lasts, otherwise scan
   // upward from the last new grant so the previous owner is checked last.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      keep        = (state_q == OWNED) && req_valid_i[owner_q] &&
                    (burst_q < CW'(BURST_MAX));
      if (keep) begin
         grant_valid = 1'b1;
         grant_idx   = owner_q;
      end else begin
         for (int d = NUM_REQ; d >= 1; d--) begin
            cand = IW'((int'(last_q) + d) % NUM_REQ);
            if (req_valid_i[cand]) begin
               grant_valid = 1'b1;
               grant_idx   = cand;
            end
         end
      end
   end

   // Track owner, burst length and rotation pointer; a rescan that lands on
   // the same requester starts a fresh burst.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= '0;
         burst_q <= '0;
         last_q  <= IW'(NUM_REQ - 1);
      end else if (!grant_valid) begin
         state_q <= IDLE;
         burst_q <= '0;
      end else if (keep) begin
         burst_q <= burst_q + CW'(1);
      end else begin
         state_q <= OWNED;
         owner_q <= grant_idx;
         burst_q <= CW'(1);
         last_q  <= grant_idx;
      end
   end
`else
   // Strict priority: the lowest-index valid requester always wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            grant_valid = 1'b1;
            grant_idx   = IW'(i);
         end
      end
   end
`endif

   // Steer the granted requester onto the memory ports; idle fields stay zero.
   always_comb begin
      req_ready_o      = '0;
      mem_read_en_o    = 1'b0;
      mem_read_pos_o   = '0;
      mem_write_en_o   = 1'b0;
      mem_write_pos_o  = '0;
      mem_write_data_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_valid && (grant_idx == IW'(i))) begin
            req_ready_o[i] = 1'b1;
            if (req_we_i[i]) begin
               mem_write_en_o   = 1'b1;
               mem_write_pos_o  = req_addr_i[i*AW +: AW];
               mem_write_data_o = req_wdata_i[i*WIDTH +: WIDTH];
            end else begin
               mem_read_en_o  = 1'b1;
               mem_read_pos_o = req_addr_i[i*AW +: AW];
            end
         end
      end
   end

   // Remember who issued this cycle's read so next cycle's data goes back to it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_pend_q <= '0;
      end else begin
         resp_pend_q <= req_ready_o & ~req_we_i;
      end
   end

   assign resp_valid_o = resp_pend_q;
   assign resp_data_o  = (|resp_pend_q) ? mem_read_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives two mem_arbiter instances (BURST_MAX = 2 and 1), each
// attached to its own behavioural memory, and compares every cycle against a
// request-level reference model. Honours MEM_ARB_FIXED_PRIO_EN when defined.
module tb_mem_arbiter;

   localparam int NR  = 2;
   localparam int W   = 32;
   localparam int DEP = 16;
   localparam int AW  = 4;

   logic clk_i;
   logic rst_ni;

   logic [NR-1:0]    valid      [2];
   logic [NR-1:0]    ready      [2];
   logic [NR-1:0]    we         [2];
   logic [NR*AW-1:0] addr       [2];
   logic [NR*W-1:0]  wdata      [2];
   logic [NR-1:0]    resp_valid [2];
   logic [W-1:0]     resp_data  [2];
   logic             mre        [2];
   logic [AW-1:0]    mrp        [2];
   logic [W-1:0]     mrd        [2];
   logic             mwe        [2];
   logic [AW-1:0]    mwp        [2];
   logic [W-1:0]     mwd        [2];

   logic [W-1:0] mem    [2][DEP];
   logic [W-1:0] refmem [2][DEP];

   // reference model state, per instance
   int          bmax [2] = '{2, 1};
   bit          m_owned [2];
   int          m_owner [2];
   int          m_run   [2];
   int          m_last  [2];
   int          m_pend  [2];
   logic [W-1:0] m_pdata [2];

   // requests held by each requester until accepted
   bit          hv  [2][NR];
   bit          hwe [2][NR];
   logic [AW-1:0] ha [2][NR];
   logic [W-1:0]  hd [2][NR];

   // last observed DUT values, for directed literal checks
   logic [NR-1:0] o_ready [2];
   logic [NR-1:0] o_rv    [2];
   logic [W-1:0]  o_rd    [2];
   logic          o_mwe   [2];

   int vectors;
   int miscompares;

   mem_arbiter #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(DEP), .BURST_MAX(2)) u_arb0 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(valid[0]), .req_ready_o(ready[0]), .req_we_i(we[0]),
      .req_addr_i(addr[0]), .req_wdata_i(wdata[0]),
      .resp_valid_o(resp_valid[0]), .resp_data_o(resp_data[0]),
      .mem_read_en_o(mre[0]), .mem_read_pos_o(mrp[0]), .mem_read_data_i(mrd[0]),
      .mem_write_en_o(mwe[0]), .mem_write_pos_o(mwp[0]), .mem_write_data_o(mwd[0])
   );

   mem_arbiter #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(DEP), .BURST_MAX(1)) u_arb1 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(valid[1]), .req_ready_o(ready[1]), .req_we_i(we[1]),
      .req_addr_i(addr[1]), .req_wdata_i(wdata[1]),
      .resp_valid_o(resp_valid[1]), .resp_data_o(resp_data[1]),
      .mem_read_en_o(mre[1]), .mem_read_pos_o(mrp[1]), .mem_read_data_i(mrd[1]),
      .mem_write_en_o(mwe[1]), .mem_write_pos_o(mwp[1]), .mem_write_data_o(mwd[1])
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // behavioural 1R1W memories with registered read
   always @(posedge clk_i) begin
      for (int k = 0; k < 2; k++) begin
         if (mwe[k]) mem[k][mwp[k]] <= mwd[k];
         if (mre[k]) mrd[k] <= mem[k][mrp[k]];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input int k, input logic [NR-1:0] v);
`ifdef MEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
`else
      if (m_owned[k] && v[m_owner[k]] && (m_run[k] < bmax[k])) return m_owner[k];
      for (int d = 1; d <= NR; d++) if (v[(m_last[k] + d) % NR]) return (m_last[k] + d) % NR;
      return -1;
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owned[k] = 0;
         m_owner[k] = 0;
         m_run[k]   = 0;
         m_last[k]  = NR - 1;
         m_pend[k]  = -1;
         m_pdata[k] = '0;
         for (int i = 0; i < NR; i++) hv[k][i] = 0;
      end
   endtask

   task automatic set_req(input int k, input int i, input bit w, input int a, input logic [W-1:0] d);
      if (!hv[k][i]) begin
         hv[k][i]  = 1;
         hwe[k][i] = w;
         ha[k][i]  = AW'(a);
         hd[k][i]  = d;
      end
   endtask

   // one clock cycle: drive held requests, compare against the model, advance
   task automatic applyStimulus();
      int g;
      logic [NR-1:0] er;
      bit ew, erd;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NR; i++) begin
            valid[k][i]          = hv[k][i];
            we[k][i]             = hwe[k][i];
            addr[k][i*AW +: AW]  = ha[k][i];
            wdata[k][i*W +: W]   = hd[k][i];
         end
      end
      #2;
      for (int k = 0; k < 2; k++) begin
         g   = model_grant(k, valid[k]);
         er  = (g >= 0) ? NR'(1 << g) : '0;
         ew  = (g >= 0) && hwe[k][g];
         erd = (g >= 0) && !hwe[k][g];
         check($sformatf("ready%0d", k), 32'(ready[k]), 32'(er));
         check($sformatf("wr_en%0d", k), 32'(mwe[k]), 32'(ew));
         check($sformatf("rd_en%0d", k), 32'(mre[k]), 32'(erd));
         check($sformatf("wr_pos%0d", k), 32'(mwp[k]), ew ? 32'(ha[k][g]) : 32'd0);
         check($sformatf("wr_data%0d", k), mwd[k], ew ? hd[k][g] : 32'd0);
         check($sformatf("rd_pos%0d", k), 32'(mrp[k]), erd ? 32'(ha[k][g]) : 32'd0);
         check($sformatf("resp_valid%0d", k), 32'(resp_valid[k]),
               (m_pend[k] >= 0) ? 32'(1 << m_pend[k]) : 32'd0);
         check($sformatf("resp_data%0d", k), resp_data[k],
               (m_pend[k] >= 0) ? m_pdata[k] : 32'd0);
         o_ready[k] = ready[k];
         o_rv[k]    = resp_valid[k];
         o_rd[k]    = resp_data[k];
         o_mwe[k]   = mwe[k];
         m_pend[k]  = -1;
         if (g >= 0) begin
            if (hwe[k][g]) begin
               refmem[k][ha[k][g]] = hd[k][g];
            end else begin
               m_pend[k]  = g;
               m_pdata[k] = refmem[k][ha[k][g]];
            end
            hv[k][g] = 0;
         end
         if (g < 0) begin
            m_owned[k] = 0;
            m_run[k]   = 0;
         end else if (m_owned[k] && g == m_owner[k] && m_run[k] < bmax[k]) begin
            m_run[k]++;
         end else begin
            m_owned[k] = 1;
            m_owner[k] = g;
            m_run[k]   = 1;
            m_last[k]  = g;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check(tag, obs, exp);
   endtask

   task automatic drain();
      for (int n = 0; n < 8; n++) begin
         if (hv[0][0] || hv[0][1] || hv[1][0] || hv[1][1]) applyStimulus();
      end
      applyStimulus();
   endtask

   logic [NR-1:0] seq0 [6];
   logic [NR-1:0] seq1 [6];

   initial begin
      vectors     = 0;
      miscompares = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
      seq0 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      seq1 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
      seq0 = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
      seq1 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
      rst_ni = 1'b0;
      for (int k = 0; k < 2; k++) begin
         valid[k] = '0; we[k] = '0; addr[k] = '0; wdata[k] = '0; mrd[k] = '0;
         for (int a = 0; a < DEP; a++) begin
            mem[k][a]    = 32'h1;
            refmem[k][a] = 32'h1;
         end
      end
      model_reset();
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // reset state: idle outputs all zero
      applyStimulus();

      // both requesters reading continuously: burst pattern
      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 0, c, '0);
            set_req(k, 1, 0, c + 8, '0);
         end
         applyStimulus();
         checkOutput($sformatf("burst_seq0_c%0d", c), 32'(o_ready[0]), 32'(seq0[c]));
         checkOutput($sformatf("burst_seq1_c%0d", c), 32'(o_ready[1]), 32'(seq1[c]));
      end
      drain();

      // req 0 reads address 5 (reset contents)
      set_req(0, 0, 0, 5, '0);
      applyStimulus();
      checkOutput("read5_ready", 32'(o_ready[0]), 32'h1);
      applyStimulus();
      checkOutput("read5_resp_valid", 32'(o_rv[0]), 32'h1);
      checkOutput("read5_resp_data", o_rd[0], 32'h1);

      // req 1 writes then reads address 10
      set_req(0, 1, 1, 10, 32'hDEADBEEF);
      applyStimulus();
      checkOutput("raw_write_en", 32'(o_mwe[0]), 32'h1);
      set_req(0, 1, 0, 10, '0);
      applyStimulus();
      applyStimulus();
      checkOutput("raw_resp_valid", 32'(o_rv[0]), 32'h2);
      checkOutput("raw_resp_data", o_rd[0], 32'hDEADBEEF);

      // single requester on the BURST_MAX = 1 instance is granted every cycle
      for (int c = 0; c < 4; c++) begin
         set_req(1, 0, 0, c, '0);
         applyStimulus();
         checkOutput($sformatf("solo_grant_c%0d", c), 32'(o_ready[1]), 32'h1);
      end
      drain();

      // reset right after an accepted read drops the response
      set_req(0, 0, 0, 3, '0);
      applyStimulus();
      rst_ni = 1'b0;
      #1;
      checkOutput("rst_resp_valid", 32'(resp_valid[0]), 32'h0);
      checkOutput("rst_resp_data", resp_data[0], 32'h0);
      model_reset();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      set_req(0, 0, 0, 1, '0);
      set_req(0, 1, 0, 2, '0);
      applyStimulus();
      checkOutput("post_rst_grant", 32'(o_ready[0]), 32'h1);
      drain();

      // randomized traffic on both instances
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) begin
               if (!hv[k][i] && ($urandom_range(0, 3) != 0)) begin
                  set_req(k, i, ($urandom_range(0, 2) == 0), int'($urandom_range(0, DEP - 1)), $urandom);
               end
            end
         end
         applyStimulus();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
